// File: rtl/uart_frame_sched.sv
// Two-channel round-robin scheduler that packs 12-bit ADC samples into
// 4-byte frames (header, channel/high nibble, low byte, XOR checksum) for the UART TX FIFO.
module uart_frame_sched #(
    parameter logic [7:0]  HEADER = 8'hA5,
    parameter int unsigned DW     = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          s0_valid,
    input  logic [DW-1:0] s0_data,
    output logic          s0_ready,
    input  logic          s1_valid,
    input  logic [DW-1:0] s1_data,
    output logic          s1_ready,
    input  logic          full,
    output logic          fifo_wr_en,
    output logic [7:0]    fifo_data_in,
    output logic          busy
);

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned PAD_W  = 3;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR  = 3'd1,
        HI   = 3'd2,
        LO   = 3'd3,
        CSUM = 3'd4
    } state_e;

    state_e          state_q, state_d;
    logic [DW-1:0]   smp_q, smp_d;
    logic            ch_id_q, ch_id_d;
    logic            last_grant_q, last_grant_d;

    logic            grant_c;
    logic            grant_vld_c;
    logic            idle_c;
    logic            xfer_c;
    logic [BYTE_W-1:0] hi_byte_c;
    logic [BYTE_W-1:0] lo_byte_c;
    logic [BYTE_W-1:0] csum_byte_c;

    // Round-robin pick; only meaningful while a source is valid.
    always_comb begin
        grant_vld_c = s0_valid | s1_valid;
        grant_c     = 1'b0;
        if (s0_valid && s1_valid) begin
            grant_c = ~last_grant_q;
        end else if (s1_valid) begin
            grant_c = 1'b1;
        end
    end

    // Ready is gated by rst_n so both stay low while reset is held.
    assign idle_c   = (state_q == IDLE);
    assign s0_ready = rst_n && idle_c && grant_vld_c && !grant_c;
    assign s1_ready = rst_n && idle_c && grant_vld_c &&  grant_c;
    assign xfer_c   = (s0_valid && s0_ready) || (s1_valid && s1_ready);

    assign hi_byte_c   = {ch_id_q, PAD_W'(0), smp_q[DW-1:BYTE_W]};
    assign lo_byte_c   = smp_q[BYTE_W-1:0];
    assign csum_byte_c = HEADER ^ hi_byte_c ^ lo_byte_c;

    assign busy       = !idle_c;
    assign fifo_wr_en = !idle_c && !full;

    // Byte mux for the current frame position.
    always_comb begin
        fifo_data_in = 8'h00;
        case (state_q)
            HDR:     fifo_data_in = HEADER;
            HI:      fifo_data_in = hi_byte_c;
            LO:      fifo_data_in = lo_byte_c;
            CSUM:    fifo_data_in = csum_byte_c;
            default: fifo_data_in = 8'h00;
        endcase
    end

    // Next-state: accept in IDLE, advance each byte state only on a real write.
    always_comb begin
        state_d      = state_q;
        smp_d        = smp_q;
        ch_id_d      = ch_id_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (xfer_c) begin
                    smp_d        = grant_c ? s1_data : s0_data;
                    ch_id_d      = grant_c;
                    last_grant_d = grant_c;
                    state_d      = HDR;
                end
            end
            HDR:     if (fifo_wr_en) state_d = HI;
            HI:      if (fifo_wr_en) state_d = LO;
            LO:      if (fifo_wr_en) state_d = CSUM;
            CSUM:    if (fifo_wr_en) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            smp_q        <= '0;
            ch_id_q      <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            smp_q        <= smp_d;
            ch_id_q      <= ch_id_d;
            last_grant_q <= last_grant_d;
        end
    end

endmodule
